// File: rtl/board_ctrl.sv
// board_ctrl -- move entry and board state for the score-4 game.
// Keeps the column cursor and the 6x7 board. It drops the current player's
// token into the lowest free cell of the selected column and toggles the turn.
// Play freezes in OVER when the downstream checker reports a win or a full board.
//
// Ports:
//   clk, rst            system clock; synchronous active-high reset
//   left, right, put    single-cycle button pulses
//   win_a, win_b        checker: four in a row for A / B (sampled in SETTLE only)
//   full_panel          checker: every cell occupied (sampled in SETTLE only)
//   panel               board, panel[row][col]; 00 empty, 01 A, 10 B; row 0 = bottom
//   play                one-hot cursor column
//   turn                0 = A to move, 1 = B to move
//   invalid             registered pulse: put rejected because the column is full
//   busy                high in FALL and SETTLE
//   game_over           high in OVER
//
// Optional feature: define DROP_ANIM_EN to animate the falling token. The token
// steps down one row every FALL_TICKS cycles. Without the macro the token is
// written in a single FALL cycle and FALL_TICKS is unused.
module board_ctrl #(
   parameter int unsigned FALL_TICKS = 12_500_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  left,
   input  logic                  right,
   input  logic                  put,
   input  logic                  win_a,
   input  logic                  win_b,
   input  logic                  full_panel,
   output logic [5:0][6:0][1:0]  panel,
   output logic [6:0]            play,
   output logic                  turn,
   output logic                  invalid,
   output logic                  busy,
   output logic                  game_over
);
   typedef enum logic [1:0] {IDLE, FALL, SETTLE, OVER} state_t;

   state_t     state, state_n;
   logic [2:0] col;
   logic [2:0] tgt_row;
   logic [2:0] scan_row;
   logic       col_full;
   logic       accept;
   logic       reject;
   logic       land;
   logic [1:0] token;

`ifdef DROP_ANIM_EN
   localparam int unsigned TICK_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
   logic [TICK_W-1:0] tick;
   logic [2:0]        anim_row;
   logic [2:0]        fall_row;
`endif

   assign token     = {turn, ~turn};
   assign play      = 7'b0000001 << col;
   assign busy      = (state == FALL) || (state == SETTLE);
   assign game_over = (state == OVER);
   assign col_full  = (panel[5][col] != 2'b00);

   // Scan from the top row down, so the last hit is the lowest empty row.
   always_comb begin
      tgt_row  = 3'd5;
      scan_row = 3'd5;
      for (int unsigned i = 0; i < 6; i++) begin
         scan_row = 3'(5 - i);
         if (panel[scan_row][col] == 2'b00) tgt_row = scan_row;
      end
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      reject  = 1'b0;
      land    = 1'b0;
      case (state)
         IDLE: begin
            if (put) begin
               if (col_full) begin
                  reject = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_n = FALL;
               end
            end
         end
         FALL: begin
`ifdef DROP_ANIM_EN
            if (anim_row == fall_row) begin
               land    = 1'b1;
               state_n = SETTLE;
            end
`else
            land    = 1'b1;
            state_n = SETTLE;
`endif
         end
         SETTLE: state_n = (win_a || win_b || full_panel) ? OVER : IDLE;
         OVER:   if (put) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         panel   <= '0;
         col     <= 3'd3;
         turn    <= 1'b0;
         invalid <= 1'b0;
`ifdef DROP_ANIM_EN
         tick     <= '0;
         anim_row <= 3'd5;
         fall_row <= 3'd5;
`endif
      end else begin
         invalid <= reject;
         case (state)
            IDLE: begin
               if (accept) begin
`ifdef DROP_ANIM_EN
                  // Target row is latched here because the board changes
                  // under the token while it falls.
                  tick     <= '0;
                  anim_row <= 3'd5;
                  fall_row <= tgt_row;
                  if (tgt_row != 3'd5) panel[5][col] <= token;
`endif
               end else if (!put && (left ^ right)) begin
                  if (left) col <= (col == 3'd0) ? 3'd6 : col - 3'd1;
                  else      col <= (col == 3'd6) ? 3'd0 : col + 3'd1;
               end
            end
            FALL: begin
`ifdef DROP_ANIM_EN
               if (land) begin
                  panel[fall_row][col] <= token;
                  turn                 <= ~turn;
               end else if (tick == TICK_W'(FALL_TICKS - 1)) begin
                  panel[anim_row][col]         <= 2'b00;
                  panel[anim_row - 3'd1][col]  <= token;
                  anim_row                     <= anim_row - 3'd1;
                  tick                         <= '0;
               end else begin
                  tick <= tick + 1'b1;
               end
`else
               if (land) begin
                  panel[tgt_row][col] <= token;
                  turn                <= ~turn;
               end
`endif
            end
            OVER: begin
               if (put) begin
                  panel <= '0;
                  turn  <= 1'b0;
                  col   <= 3'd3;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl -- self-checking bench for board_ctrl.
// A move-level board model (array + lowest-free-row rule + four-in-a-row
// search) drives the checker inputs and predicts every visible output.
// The cursor vectors come from a table, the corner cases from hand-written
// sequences, and the bulk of the run from random button streams.
module tb_board_ctrl;
   localparam int unsigned T = 4;
`ifdef DROP_ANIM_EN
   localparam bit ANIM = 1'b1;
`else
   localparam bit ANIM = 1'b0;
`endif

   typedef logic [5:0][6:0][1:0] board_t;

   logic       clk = 1'b0;
   logic       rst, left, right, put, win_a, win_b, full_panel;
   board_t     panel;
   logic [6:0] play;
   logic       turn, invalid, busy, game_over;

   board_ctrl #(.FALL_TICKS(T)) dut (
      .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
      .win_a(win_a), .win_b(win_b), .full_panel(full_panel),
      .panel(panel), .play(play), .turn(turn), .invalid(invalid),
      .busy(busy), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int brd[6][7];
   int m_col;
   bit m_turn;
   bit m_over;

   typedef struct {
      bit         l, r, p;
      logic [6:0] exp_play;
      logic       exp_turn;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic board_t m_panel();
      board_t p;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            p[r][c] = 2'(brd[r][c]);
      return p;
   endfunction

   function automatic int lowest(input int c);
      for (int r = 0; r < 6; r++)
         if (brd[r][c] == 0) return r;
      return -1;
   endfunction

   function automatic bit four(input int p);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            for (int d = 0; d < 4; d++) begin
               int dr, dc;
               bit ok;
               dr = (d == 0) ? 0 : 1;
               dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
               ok = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  int rr, cc;
                  rr = r + k * dr;
                  cc = c + k * dc;
                  if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
                  else if (brd[rr][cc] != p) ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   function automatic bit all_full();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            if (brd[r][c] == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            brd[r][c] = 0;
      m_col  = 3;
      m_turn = 1'b0;
      m_over = 1'b0;
   endtask

   task automatic set_checker();
      win_a      = four(1);
      win_b      = four(2);
      full_panel = all_full();
   endtask

   task automatic check_state(input string tag);
      check($sformatf("%s.play", tag), play, 7'b0000001 << m_col);
      check($sformatf("%s.turn", tag), turn, m_turn);
      check($sformatf("%s.panel", tag), panel, m_panel());
      check($sformatf("%s.over", tag), game_over, m_over);
      check($sformatf("%s.busy", tag), busy, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_clear();
      set_checker();
      check_state("reset");
      check("reset.invalid", invalid, 1'b0);
   endtask

   // One button cycle followed by whatever the model says the move takes.
   task automatic do_op(input bit l, input bit r, input bit p);
      int row, cyc, exp_cyc;
      left = l; right = r; put = p;
      step();
      left = 1'b0; right = 1'b0; put = 1'b0;
      if (m_over) begin
         if (p) begin
            m_clear();
            set_checker();
         end
         check("over.invalid", invalid, 1'b0);
      end else if (p) begin
         row = lowest(m_col);
         if (row < 0) begin
            check("full.invalid_hi", invalid, 1'b1);
            check("full.busy", busy, 1'b0);
            step();
            check("full.invalid_lo", invalid, 1'b0);
         end else begin
            check("put.invalid", invalid, 1'b0);
            brd[row][m_col] = m_turn ? 2 : 1;
            m_turn = !m_turn;
            set_checker();
            exp_cyc = ANIM ? (5 - row) * int'(T) + 2 : 2;
            cyc = 0;
            // Buttons pressed while busy must all be dropped.
            while (busy && cyc < 200) begin
               left  = 1'($urandom_range(1));
               right = 1'($urandom_range(1));
               put   = 1'($urandom_range(1));
               step();
               cyc++;
               left = 1'b0; right = 1'b0; put = 1'b0;
            end
            check("put.busy_cycles", cyc, exp_cyc);
            m_over = four(1) || four(2) || all_full();
         end
      end else begin
         if (l ^ r) m_col = (m_col + (l ? 6 : 1)) % 7;
         check("move.invalid", invalid, 1'b0);
      end
      check_state("op");
   endtask

   task automatic goto_col(input int c);
      for (int i = 0; i < 7 && m_col != c; i++) do_op(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: run did not finish (tests %0d)", tests);
      $fatal(1);
   end

   initial begin
      vec_t vecs[9];
      board_t exp_b;

      rst = 1'b1; left = 1'b0; right = 1'b0; put = 1'b0;
      win_a = 1'b0; win_b = 1'b0; full_panel = 1'b0;
      m_clear();
      step();

      // Cursor table: wraps, ignored L+R, put with a move.
      vecs[0] = '{l:0, r:1, p:0, exp_play:7'b0010000, exp_turn:0};
      vecs[1] = '{l:0, r:1, p:0, exp_play:7'b0100000, exp_turn:0};
      vecs[2] = '{l:0, r:1, p:0, exp_play:7'b1000000, exp_turn:0};
      vecs[3] = '{l:0, r:1, p:0, exp_play:7'b0000001, exp_turn:0};
      vecs[4] = '{l:1, r:0, p:0, exp_play:7'b1000000, exp_turn:0};
      vecs[5] = '{l:0, r:1, p:0, exp_play:7'b0000001, exp_turn:0};
      vecs[6] = '{l:1, r:1, p:0, exp_play:7'b0000001, exp_turn:0};
      vecs[7] = '{l:0, r:1, p:1, exp_play:7'b0000001, exp_turn:1};
      vecs[8] = '{l:1, r:0, p:0, exp_play:7'b1000000, exp_turn:1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].l, vecs[i].r, vecs[i].p);
         check($sformatf("vec%0d.play", i), play, vecs[i].exp_play);
         check($sformatf("vec%0d.turn", i), turn, vecs[i].exp_turn);
      end

      // Two puts on column 3.
      do_reset();
      do_op(1'b0, 1'b0, 1'b1);
      check("col3.first", panel[0][3], 2'b01);
      check("col3.turn1", turn, 1'b1);
      do_op(1'b0, 1'b0, 1'b1);
      check("col3.second", panel[1][3], 2'b10);
      check("col3.turn0", turn, 1'b0);

      // Full column 0 rejects the seventh put.
      do_reset();
      goto_col(0);
      for (int i = 0; i < 6; i++) do_op(1'b0, 1'b0, 1'b1);
      do_op(1'b0, 1'b0, 1'b1);

      // A wins along the bottom row; OVER freezes, put restarts.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         goto_col(c);
         do_op(1'b0, 1'b0, 1'b1);
         if (c < 3) begin
            goto_col(6);
            do_op(1'b0, 1'b0, 1'b1);
         end
      end
      check("win.game_over", game_over, 1'b1);
      do_op(1'b1, 1'b0, 1'b0);
      do_op(1'b0, 1'b1, 1'b0);
      do_op(1'b1, 1'b1, 1'b0);
      do_op(1'b0, 1'b0, 1'b1);
      check("restart.play", play, 7'b0001000);
      check("restart.over", game_over, 1'b0);
      check("restart.panel", panel, '0);

      // Reset while the token is in flight.
      do_reset();
      do_op(1'b0, 1'b0, 1'b1);
      put = 1'b1;
      step();
      put = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midfall.panel", panel, '0);
      check("midfall.turn", turn, 1'b0);
      check("midfall.play", play, 7'b0001000);
      check("midfall.busy", busy, 1'b0);
      m_clear();
      set_checker();

`ifdef DROP_ANIM_EN
      // Animated drop into an empty column: rows 5..0, T cycles each.
      do_reset();
      put = 1'b1;
      step();
      put = 1'b0;
      for (int k = 0; k < 24; k++) begin
         exp_b = '0;
         exp_b[5 - k / 4][3] = 2'b01;
         check($sformatf("anim.k%0d", k), panel, exp_b);
         if (k < 23) step();
      end
      brd[0][3] = 1;
      m_turn = 1'b1;
      set_checker();
      check_state("anim.end");
      // Reset mid-animation.
      put = 1'b1;
      step();
      put = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("anim_rst.panel", panel, '0);
      check("anim_rst.turn", turn, 1'b0);
      m_clear();
      set_checker();
`endif

      // Random play against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         int op;
         op = int'($urandom_range(9));
         case (op)
            0, 1, 2: do_op(1'b1, 1'b0, 1'b0);
            3, 4, 5: do_op(1'b0, 1'b1, 1'b0);
            6:       do_op(1'b1, 1'b1, 1'b0);
            7, 8:    do_op(1'b0, 1'b0, 1'b1);
            default: do_op(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
